uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common to uart_tx and uart_rx),
// frame width and the mid-bit sampling helper.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_START     = ST_START,
        S_DATA      = ST_DATA,
        S_STOP      = ST_STOP,
        S_WAIT_HIGH = ST_WAIT_HIGH
    } uart_state_e;

    // Tick index at which the start bit is re-checked, half a bit after the edge.
    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: sample tick and serial line in, byte and status out.
interface uart_rx_if
    import uart_pkg::*;
();
    logic              en;
    logic              in;
    logic [DATA_W-1:0] out;
    logic              valid;
    logic              frame_err;
    logic              busy;

    modport master (
        output en,
        output in,
        input  out,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both stages reset to RST_VAL.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1, LSB first, mid-bit sampling, one-clock
// valid / frame_err pulses, and a WAIT_HIGH state that absorbs line breaks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_rx_if.slave   rx_if
);
    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(mid_tick(OVERSAMPLE));
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    logic rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_if.in),
        .q_o   (rx_s)
    );

    uart_state_e       state_q, state_d;
    logic [TW-1:0]     tick_q,  tick_d;
    logic [2:0]        bit_q,   bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] out_q,   out_d;
    logic              valid_q, valid_d;
    logic              ferr_q,  ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // The shift register only ever feeds out_q after a full frame, so it needs no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_if.en && !rx_s) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end

            S_START: begin
                if (rx_if.en) begin
                    if (tick_q == MID_TICK) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            S_DATA: begin
                if (rx_if.en) begin
                    if (tick_q == LAST_TICK) begin
                        shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
                        tick_d  = '0;
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            S_STOP: begin
                if (rx_if.en) begin
                    if (tick_q == LAST_TICK) begin
                        tick_d = '0;
                        if (rx_s) begin
                            out_d   = shreg_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_HIGH;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            S_WAIT_HIGH: begin
                if (rx_if.en && rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign rx_if.out       = out_q;
    assign rx_if.valid     = valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.busy      = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, glitch, break, back-to-back,
// mid-frame reset and a slow sample tick.
module tb_uart_rx;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   en_div;
    int   en_cnt;

    int total = 0;
    int bad   = 0;

    int         vcnt = 0;
    int         fcnt = 0;
    int         wide = 0;
    int         overlap = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] cap [0:63];

    int v0;
    int f0;

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (bus)
    );

    always #5 clk = ~clk;

    // Sample tick: one pulse every en_div clocks, changed on the falling edge.
    initial begin
        en_cnt = 0;
        bus.en = 1'b0;
        forever begin
            @(negedge clk);
            if (en_cnt >= en_div - 1) begin
                bus.en = 1'b1;
                en_cnt = 0;
            end else begin
                bus.en = 1'b0;
                en_cnt++;
            end
        end
    end

    // Pulse monitor, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.valid) begin
            cap[vcnt % 64] = bus.out;
            vcnt++;
            if (valid_prev) wide++;
        end
        if (bus.frame_err) fcnt++;
        if (bus.valid && bus.frame_err) overlap++;
        valid_prev = bus.valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic hold(input logic v, input int ticks);
        bus.in = v;
        repeat (ticks * en_div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        hold(1'b0, OS);
        for (int i = 0; i < 8; i++) hold(b[i], OS);
        hold(stop, OS);
    endtask

    initial begin
        logic [7:0] b;
        rst_n  = 1'b0;
        en_div = 1;
        bus.in = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_out",   32'(bus.out),       32'h00);
        check("rst_valid", 32'(bus.valid),     32'h0);
        check("rst_ferr",  32'(bus.frame_err), 32'h0);
        check("rst_busy",  32'(bus.busy),      32'h0);
        rst_n = 1'b1;
        hold(1'b1, 4);

        // 1: frame A5, busy checked mid-frame
        v0 = vcnt;
        b  = 8'hA5;
        hold(1'b0, OS);
        for (int i = 0; i < 5; i++) hold(b[i], OS);
        check("t1_busy_mid", 32'(bus.busy), 32'h1);
        for (int i = 5; i < 8; i++) hold(b[i], OS);
        hold(1'b1, OS);
        hold(1'b1, OS);
        check("t1_vcnt", 32'(vcnt - v0), 32'd1);
        check("t1_cap",  32'(cap[v0 % 64]), 32'hA5);
        check("t1_out",  32'(bus.out), 32'hA5);
        check("t1_fcnt", 32'(fcnt), 32'd0);
        check("t1_busy_end", 32'(bus.busy), 32'h0);

        // 2: 5-tick glitch, then frame 3C
        v0 = vcnt;
        hold(1'b0, 5);
        hold(1'b1, 20);
        check("t2_busy", 32'(bus.busy), 32'h0);
        check("t2_vcnt", 32'(vcnt - v0), 32'd0);
        check("t2_fcnt", 32'(fcnt), 32'd0);
        send_frame(8'h3C, 1'b1);
        hold(1'b1, OS);
        check("t2_vcnt2", 32'(vcnt - v0), 32'd1);
        check("t2_out",   32'(bus.out), 32'h3C);

        // 3: frame 81 with low stop bit, then a 40-bit break, then frame 55
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'h81, 1'b0);
        hold(1'b0, 20 * OS);
        check("t3_busy_brk", 32'(bus.busy), 32'h0);
        check("t3_fcnt_mid", 32'(fcnt - f0), 32'd1);
        hold(1'b0, 20 * OS);
        check("t3_fcnt", 32'(fcnt - f0), 32'd1);
        check("t3_vcnt", 32'(vcnt - v0), 32'd0);
        check("t3_out_kept", 32'(bus.out), 32'h3C);
        hold(1'b1, 20);
        send_frame(8'h55, 1'b1);
        hold(1'b1, OS);
        check("t3_vcnt2", 32'(vcnt - v0), 32'd1);
        check("t3_out",   32'(bus.out), 32'h55);

        // 4: back-to-back 00 and FF
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, OS);
        check("t4_vcnt",  32'(vcnt - v0), 32'd2);
        check("t4_cap0",  32'(cap[v0 % 64]), 32'h00);
        check("t4_cap1",  32'(cap[(v0 + 1) % 64]), 32'hFF);
        check("t4_fcnt",  32'(fcnt - f0), 32'd0);

        // 5: reset during data bit 4 of 5A, then C3
        v0 = vcnt;
        f0 = fcnt;
        b  = 8'h5A;
        hold(1'b0, OS);
        for (int i = 0; i < 4; i++) hold(b[i], OS);
        bus.in = b[4];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rst_out",   32'(bus.out),       32'h00);
        check("t5_rst_valid", 32'(bus.valid),     32'h0);
        check("t5_rst_busy",  32'(bus.busy),      32'h0);
        check("t5_rst_ferr",  32'(bus.frame_err), 32'h0);
        bus.in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 20);
        check("t5_vcnt", 32'(vcnt - v0), 32'd0);
        check("t5_fcnt", 32'(fcnt - f0), 32'd0);
        send_frame(8'hC3, 1'b1);
        hold(1'b1, OS);
        check("t5_vcnt2", 32'(vcnt - v0), 32'd1);
        check("t5_out",   32'(bus.out), 32'hC3);

        // 6: sample tick every 3rd clock, frame 96
        en_div = 3;
        hold(1'b1, 4);
        v0 = vcnt;
        send_frame(8'h96, 1'b1);
        hold(1'b1, OS);
        check("t6_vcnt",    32'(vcnt - v0), 32'd1);
        check("t6_out",     32'(bus.out), 32'h96);
        check("t6_wide",    32'(wide), 32'd0);
        check("t6_overlap", 32'(overlap), 32'd0);
        check("t6_fcnt",    32'(fcnt - f0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
